// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_e  : controller states (IDLE / RUN / DONE)
//   NIBBLE_W : bits processed per clock by the lookahead slice
//   clog2_f  : ceiling log2, used to size the nibble counter
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns at least 1 so a counter declared from it always has a bit.
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead slice, purely combinational.
// Ports:
//   i_a, i_b [3:0] : operand nibbles
//   i_ci           : carry into bit 0
//   o_s [3:0]      : sum nibble
//   o_c3           : carry into bit 3 (needed for signed overflow)
//   o_c4           : carry out of bit 3
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_c3,
    output logic       o_c4
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Fully expanded lookahead terms; no carry ripples between bits.
    assign w_c1 = w_g[0] | (w_p[0] & i_ci);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign o_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign o_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s = w_p ^ {o_c3, w_c2, w_c1, i_ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice per clock, carry
// registered between nibbles. Upstream and downstream valid/ready handshakes.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum  : a + b + cin modulo 2^WIDTH
//   cout : carry out of bit WIDTH-1
//   ovf  : signed overflow (carry into MSB xor carry out of MSB)
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W = clog2_f(NIB);

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;
    logic [3:0]         w_s;
    logic               w_c3;
    logic               w_c4;

    assign w_last = (r_cnt == CNT_W'(NIB - 1));

    cla4_slice u_slice (
        .i_a  (r_a[3:0]),
        .i_b  (r_b[3:0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_c3 (w_c3),
        .o_c4 (w_c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    // Sum nibbles enter at the top so the LSB nibble ends at bit 0.
                    r_result <= {w_s, r_result[WIDTH-1:NIBBLE_W]};
                    r_carry  <= w_c4;
                    r_a      <= r_a >> NIBBLE_W;
                    r_b      <= r_b >> NIBBLE_W;
                    if (w_last) begin
                        r_ovf <= w_c3 ^ w_c4;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_result;
    assign cout = r_carry;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   checks;
    int   failures;
    exp_t sb[$];
    vec_t vecs[7];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                   input logic tc);
        exp_t             e;
        logic [WIDTH:0]   full;
        full   = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (ta[WIDTH-1] == tb[WIDTH-1]) && (e.sum[WIDTH-1] != ta[WIDTH-1]);
        return e;
    endfunction

    // One add through the handshake; optionally stalls the consumer for hold cycles
    // while waving new operands at the (busy) input.
    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tc, input exp_t e, input int hold);
        int               lat;
        exp_t             got;
        logic [WIDTH-1:0] s0;
        logic             c0;
        logic             o0;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tc;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(NIB));
        if (!out_valid) begin
            void'(sb.pop_front());
            return;
        end
        s0 = sum;
        c0 = cout;
        o0 = ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            a        = 16'hA5A5 ^ 16'(i);
            b        = 16'h5A5A;
            cin      = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_stable", {15'd0, sum, cout}, {15'd0, s0, c0});
            check("hold_ovf", 32'(ovf), 32'(o0));
        end
        in_valid = 1'b0;
        got = sb.pop_front();
        check("sum", 32'(sum), 32'(got.sum));
        check("cout", 32'(cout), 32'(got.cout));
        check("ovf", 32'(ovf), 32'(got.ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   nsent;
        int   nres;
        int   cycle;
        int   last_acc;
        exp_t e;
        exp_t got;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outs", {15'd0, sum, cout}, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            e.sum  = vecs[i].sum;
            e.cout = vecs[i].cout;
            e.ovf  = vecs[i].ovf;
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, e, (i == 0) ? 5 : 0);
        end

        // Reset two cycles into RUN: must drop straight to reset values.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hBEEF;
        b        = 16'h1111;
        cin      = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outs", {15'd0, sum, cout}, 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e.sum  = 16'h0007;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        run_add(16'h0003, 16'h0004, 1'b0, e, 0);

        // Back-to-back random stream with both handshakes held high.
        out_ready = 1'b1;
        nsent     = 0;
        nres      = 0;
        cycle     = 0;
        last_acc  = 0;
        while (nres < 200 && cycle < 200 * (NIB + 2) + 100) begin
            @(negedge clk);
            cycle++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("b2b_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("b2b_result", {14'd0, sum, cout, ovf}, {14'd0, got.sum, got.cout, got.ovf});
                    nres++;
                end
            end
            if (in_ready && nsent < 200) begin
                ra       = 16'($urandom);
                rb       = 16'($urandom);
                rc       = 1'($urandom);
                if (nsent % 50 == 0) begin
                    ra = 16'hFFFF;
                    rb = 16'hFFFF;
                    rc = 1'b1;
                end
                a        = ra;
                b        = rb;
                cin      = rc;
                in_valid = 1'b1;
                sb.push_back(model(ra, rb, rc));
                if (nsent > 0) begin
                    check("b2b_spacing", 32'(cycle - last_acc), 32'(NIB + 2));
                end
                last_acc = cycle;
                nsent++;
            end else if (nsent >= 200) begin
                in_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(nres), 32'd200);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
